// File: rtl/memory_request_arbiter.sv
// Arbitrates the single data-cache controller port between the load and store units.
// Loads win by default; a same-word store or a starved store takes the port instead.
module memory_request_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ldu_request_i,
  input  logic [XLEN-1:0] ldu_address_i,
  output logic            ldu_grant_o,
  output logic            ldu_done_o,
  input  logic            stu_request_i,
  input  logic [XLEN-1:0] stu_address_i,
  output logic            stu_idle_o,
  output logic            stu_grant_o,
  output logic            stu_done_o,
  input  logic            cache_idle_i,
  input  logic            cache_done_i,
  output logic            cache_read_o,
  output logic            cache_write_o,
  output logic [XLEN-1:0] cache_address_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_LOAD,
    GRANT_STORE
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       word_conflict;
  logic       arb_en;
  logic       store_wins;
  logic       store_take;
  logic       load_take;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  // Byte offset is ignored: any overlap within the same word forces the store first.
  assign word_conflict = (ldu_address_i[XLEN-1:2] == stu_address_i[XLEN-1:2]);
  assign arb_en        = (state == IDLE) && cache_idle_i;
  assign store_wins    = stu_request_i &&
                         (!ldu_request_i || word_conflict || (starve_cnt == LIMIT));
  assign store_take    = arb_en && store_wins;
  assign load_take     = arb_en && ldu_request_i && !store_wins;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      ldu_grant_o     <= 1'b0;
      stu_grant_o     <= 1'b0;
      cache_read_o    <= 1'b0;
      cache_write_o   <= 1'b0;
      cache_address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_take) begin
            state           <= GRANT_STORE;
            stu_grant_o     <= 1'b1;
            cache_write_o   <= 1'b1;
            cache_address_o <= stu_address_i;
          end else if (load_take) begin
            state           <= GRANT_LOAD;
            ldu_grant_o     <= 1'b1;
            cache_read_o    <= 1'b1;
            cache_address_o <= ldu_address_i;
          end
        end
        GRANT_LOAD: begin
          if (cache_done_i) begin
            state        <= IDLE;
            ldu_grant_o  <= 1'b0;
            cache_read_o <= 1'b0;
          end
        end
        GRANT_STORE: begin
          if (cache_done_i) begin
            state         <= IDLE;
            stu_grant_o   <= 1'b0;
            cache_write_o <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          ldu_grant_o   <= 1'b0;
          stu_grant_o   <= 1'b0;
          cache_read_o  <= 1'b0;
          cache_write_o <= 1'b0;
        end
      endcase
    end
  end

  // Counts loads granted past a waiting store; any cycle without a store request clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= 4'd0;
    end else if (!stu_request_i || store_take) begin
      starve_cnt <= 4'd0;
    end else if (load_take) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  assign ldu_done_o = (state == GRANT_LOAD) && cache_done_i;
  assign stu_done_o = (state == GRANT_STORE) && cache_done_i;
  assign stu_idle_o = cache_idle_i && (state != GRANT_LOAD);

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Bench for memory_request_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a port-ownership model.
module tb_memory_request_arbiter;

  localparam int XLEN = 32;
  localparam int LIM  = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            ldu_request_i = 1'b0;
  logic [XLEN-1:0] ldu_address_i = '0;
  logic            ldu_grant_o;
  logic            ldu_done_o;
  logic            stu_request_i = 1'b0;
  logic [XLEN-1:0] stu_address_i = '0;
  logic            stu_idle_o;
  logic            stu_grant_o;
  logic            stu_done_o;
  logic            cache_idle_i = 1'b0;
  logic            cache_done_i = 1'b0;
  logic            cache_read_o;
  logic            cache_write_o;
  logic [XLEN-1:0] cache_address_o;

  memory_request_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .ldu_request_i  (ldu_request_i),
    .ldu_address_i  (ldu_address_i),
    .ldu_grant_o    (ldu_grant_o),
    .ldu_done_o     (ldu_done_o),
    .stu_request_i  (stu_request_i),
    .stu_address_i  (stu_address_i),
    .stu_idle_o     (stu_idle_o),
    .stu_grant_o    (stu_grant_o),
    .stu_done_o     (stu_done_o),
    .cache_idle_i   (cache_idle_i),
    .cache_done_i   (cache_done_i),
    .cache_read_o   (cache_read_o),
    .cache_write_o  (cache_write_o),
    .cache_address_o(cache_address_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the port (0 none, 1 load, 2 store), the address handed out,
  // and how many loads have overtaken the currently waiting store.
  int              m_owner = 0;
  logic [XLEN-1:0] m_addr = '0;
  int              m_starve = 0;
  int              m_win;

  always_comb begin
    m_win = 0;
    if (m_owner == 0 && cache_idle_i) begin
      if (ldu_request_i && stu_request_i)
        m_win = ((ldu_address_i / 4) == (stu_address_i / 4) || m_starve == LIM) ? 2 : 1;
      else if (ldu_request_i) m_win = 1;
      else if (stu_request_i) m_win = 2;
    end
  end

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_owner  <= 0;
      m_addr   <= '0;
      m_starve <= 0;
    end else begin
      if (m_win != 0) begin
        m_owner <= m_win;
        m_addr  <= (m_win == 1) ? ldu_address_i : stu_address_i;
      end else if (m_owner != 0 && cache_done_i) begin
        m_owner <= 0;
      end
      if (!stu_request_i || m_win == 2) m_starve <= 0;
      else if (m_win == 1) m_starve <= (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("ldu_grant", 32'(ldu_grant_o), 32'(m_owner == 1));
      chk("cache_read", 32'(cache_read_o), 32'(m_owner == 1));
      chk("stu_grant", 32'(stu_grant_o), 32'(m_owner == 2));
      chk("cache_write", 32'(cache_write_o), 32'(m_owner == 2));
      chk("cache_address", cache_address_o, m_addr);
      chk("ldu_done", 32'(ldu_done_o), 32'(m_owner == 1 && cache_done_i));
      chk("stu_done", 32'(stu_done_o), 32'(m_owner == 2 && cache_done_i));
      chk("stu_idle", 32'(stu_idle_o), 32'(cache_idle_i && m_owner != 1));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rand_addr();
    return 32'h0000_1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit fin_l;
    bit fin_s;
    int busy;
    int target;

    // Reset with a pending store: nothing granted, stu_idle_o follows cache_idle_i.
    stu_request_i = 1'b1;
    stu_address_i = 32'h0000_0500;
    repeat (2) @(posedge clk_i);
    cmp_en = 1'b1;
    #1;
    chk("rst_stu_idle_low", 32'(stu_idle_o), 32'd0);
    cache_idle_i = 1'b1;
    #1;
    chk("rst_stu_idle_high", 32'(stu_idle_o), 32'd1);
    chk("rst_stu_grant", 32'(stu_grant_o), 32'd0);
    chk("rst_cache_write", 32'(cache_write_o), 32'd0);
    chk("rst_address", cache_address_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("post_rst_no_grant_yet", 32'(stu_grant_o), 32'd0);
    step();
    chk("post_rst_stu_grant", 32'(stu_grant_o), 32'd1);
    chk("post_rst_address", cache_address_o, 32'h0000_0500);
    cache_done_i = 1'b1;
    #1;
    chk("post_rst_stu_done", 32'(stu_done_o), 32'd1);
    step();
    cache_done_i  = 1'b0;
    stu_request_i = 1'b0;
    chk("post_rst_back_idle", 32'(stu_grant_o), 32'd0);

    // Single load at 0x1004, done in cycle 4.
    ldu_request_i = 1'b1;
    ldu_address_i = 32'h0000_1004;
    step();
    chk("load_read", 32'(cache_read_o), 32'd1);
    chk("load_address", cache_address_o, 32'h0000_1004);
    repeat (3) step();
    cache_done_i = 1'b1;
    #1;
    chk("load_done", 32'(ldu_done_o), 32'd1);
    step();
    cache_done_i  = 1'b0;
    ldu_request_i = 1'b0;
    chk("load_idle_again", 32'(ldu_grant_o), 32'd0);

    // Contention without a word conflict: load first, store one cycle after the load's done.
    ldu_request_i = 1'b1;
    ldu_address_i = 32'h0000_0100;
    stu_request_i = 1'b1;
    stu_address_i = 32'h0000_0200;
    step();
    chk("cont_ldu_grant", 32'(ldu_grant_o), 32'd1);
    chk("cont_address_ld", cache_address_o, 32'h0000_0100);
    chk("cont_stu_idle_gated", 32'(stu_idle_o), 32'd0);
    cache_done_i = 1'b1;
    #1;
    chk("cont_ldu_done", 32'(ldu_done_o), 32'd1);
    step();
    cache_done_i  = 1'b0;
    ldu_request_i = 1'b0;
    chk("cont_bubble_stu_grant", 32'(stu_grant_o), 32'd0);
    chk("cont_bubble_stu_idle", 32'(stu_idle_o), 32'd1);
    step();
    chk("cont_stu_grant", 32'(stu_grant_o), 32'd1);
    chk("cont_address_st", cache_address_o, 32'h0000_0200);
    cache_done_i = 1'b1;
    step();
    cache_done_i  = 1'b0;
    stu_request_i = 1'b0;
    cache_done_i  = 1'b1;
    #1;
    chk("spurious_ldu_done", 32'(ldu_done_o), 32'd0);
    chk("spurious_stu_done", 32'(stu_done_o), 32'd0);
    step();
    cache_done_i = 1'b0;

    // Word conflict: the store wins even though a load is pending.
    ldu_request_i = 1'b1;
    ldu_address_i = 32'h0000_2002;
    stu_request_i = 1'b1;
    stu_address_i = 32'h0000_2000;
    step();
    chk("conflict_write", 32'(cache_write_o), 32'd1);
    chk("conflict_ldu_grant", 32'(ldu_grant_o), 32'd0);
    chk("conflict_address", cache_address_o, 32'h0000_2000);
    cache_done_i = 1'b1;
    step();
    cache_done_i  = 1'b0;
    stu_request_i = 1'b0;
    step();
    chk("conflict_then_load", 32'(ldu_grant_o), 32'd1);
    chk("conflict_load_addr", cache_address_o, 32'h0000_2002);
    cache_done_i = 1'b1;
    step();
    cache_done_i  = 1'b0;
    ldu_request_i = 1'b0;

    // Starvation: four loads overtake the waiting store, then the store gets the port.
    stu_request_i = 1'b1;
    stu_address_i = 32'h0000_3000;
    ldu_request_i = 1'b1;
    ldu_address_i = 32'h0000_4000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin
        chk("starve_load_grant", 32'(ldu_grant_o), 32'd1);
        chk("starve_load_addr", cache_address_o, 32'h0000_4000 + 32'(4 * i));
      end else begin
        chk("starve_store_grant", 32'(stu_grant_o), 32'd1);
        chk("starve_store_addr", cache_address_o, 32'h0000_3000);
      end
      cache_done_i = 1'b1;
      step();
      cache_done_i = 1'b0;
      if (i < 4) begin
        ldu_address_i = 32'h0000_4000 + 32'(4 * (i + 1));
      end else begin
        stu_request_i = 1'b0;
        ldu_request_i = 1'b0;
      end
    end
    // A cleared counter lets the next load win over a new store.
    stu_request_i = 1'b1;
    stu_address_i = 32'h0000_3100;
    ldu_request_i = 1'b1;
    ldu_address_i = 32'h0000_5000;
    step();
    chk("starve_cleared_load_wins", 32'(ldu_grant_o), 32'd1);

    // Asynchronous reset in the middle of a granted load.
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_ldu_grant", 32'(ldu_grant_o), 32'd0);
    chk("midrst_read", 32'(cache_read_o), 32'd0);
    chk("midrst_address", cache_address_o, 32'd0);
    chk("midrst_stu_idle", 32'(stu_idle_o), 32'd1);
    ldu_request_i = 1'b0;
    stu_request_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    // Random traffic: requesters hold until their done, cache completes after 1-4 cycles.
    busy   = 0;
    target = int'($urandom_range(0, 3));
    for (int c = 0; c < 4000; c++) begin
      fin_l = ldu_request_i && m_owner == 1 && cache_done_i;
      fin_s = stu_request_i && m_owner == 2 && cache_done_i;
      step();
      if (fin_l) ldu_request_i = 1'b0;
      if (fin_s) stu_request_i = 1'b0;
      if (!ldu_request_i && $urandom_range(0, 1) == 1) begin
        ldu_request_i = 1'b1;
        ldu_address_i = rand_addr();
      end
      if (!stu_request_i && $urandom_range(0, 2) == 0) begin
        stu_request_i = 1'b1;
        stu_address_i = rand_addr();
      end
      cache_idle_i = ($urandom_range(0, 4) != 0);
      cache_done_i = 1'b0;
      if (m_owner != 0) begin
        if (busy >= target) begin
          cache_done_i = 1'b1;
          busy   = 0;
          target = int'($urandom_range(0, 3));
        end else begin
          busy++;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        cache_done_i = 1'b1;
      end
    end

    @(negedge clk_i);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
